// File: rtl/recirculacion_rx.sv
// Receive-side recirculation block: registered valid path, tester FIFO
// with ready/valid hand-off, and saturating forward/drop statistics.
module recirculacion_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] In0,
    input  logic [DATA_WIDTH-1:0] In1,
    input  logic [DATA_WIDTH-1:0] In2,
    input  logic [DATA_WIDTH-1:0] In3,
    input  logic                  validIn,
    input  logic                  capture_en,
    input  logic                  clear_stats,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2,
    output logic [DATA_WIDTH-1:0] data_out3,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_Probador0,
    output logic [DATA_WIDTH-1:0] data_Probador1,
    output logic [DATA_WIDTH-1:0] data_Probador2,
    output logic [DATA_WIDTH-1:0] data_Probador3,
    output logic                  probe_valid,
    input  logic                  probe_ready,
    output logic [CNT_WIDTH-1:0]  fwd_count,
    output logic [CNT_WIDTH-1:0]  drop_count,
    output logic                  overflow
);

    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WW = 4 * DATA_WIDTH;
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    logic [WW-1:0]        in_word;
    logic [WW-1:0]        dout_q, dout_d;
    logic                 vout_q;
    logic [WW-1:0]        mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW:0]          count_q, count_d;
    logic [CNT_WIDTH-1:0] fwd_q, fwd_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;
    logic                 ovf_q, ovf_d;
    logic                 empty, full;
    logic                 push_req, push, pop, drop;
    logic [WW-1:0]        head;

    assign in_word  = {In3, In2, In1, In0};
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign pop      = !empty && probe_ready;
    assign push_req = !validIn && capture_en;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    // Valid path: zero the lanes whenever the incoming word is not valid.
    always_comb begin
        dout_d = validIn ? in_word : '0;
    end

    // Registered valid-path lanes and qualifier.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q <= '0;
            vout_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vout_q <= validIn;
        end
    end

    // FIFO pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are masked by the empty flag, so no reset.
    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= in_word;
    end

    // Statistics next-state; clear dominates any coincident event.
    always_comb begin
        fwd_d  = fwd_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (validIn && fwd_q != '1) fwd_d = fwd_q + 1'b1;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 1'b1;
        end
        if (clear_stats) begin
            fwd_d  = '0;
            drop_d = '0;
            ovf_d  = 1'b0;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            fwd_q  <= fwd_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q];

    assign data_out0      = dout_q[DATA_WIDTH-1:0];
    assign data_out1      = dout_q[2*DATA_WIDTH-1:DATA_WIDTH];
    assign data_out2      = dout_q[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign data_out3      = dout_q[4*DATA_WIDTH-1:3*DATA_WIDTH];
    assign valid_out      = vout_q;
    assign data_Probador0 = head[DATA_WIDTH-1:0];
    assign data_Probador1 = head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign data_Probador2 = head[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign data_Probador3 = head[4*DATA_WIDTH-1:3*DATA_WIDTH];
    assign probe_valid    = !empty;
    assign fwd_count      = fwd_q;
    assign drop_count     = drop_q;
    assign overflow       = ovf_q;

endmodule
